// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 2-read/1-write register file with word 0 hardwired to zero.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_2r1w #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rsNum,
  output logic [WIDTH-1:0]      rsData,
  input  logic [ADDR_WIDTH-1:0] rtNum,
  output logic [WIDTH-1:0]      rtData,
  input  logic [ADDR_WIDTH-1:0] rdNum,
  input  logic [WIDTH-1:0]      rdData,
  input  logic                  rdWriteEnable
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0] word_en;
  logic [WIDTH-1:0] mem_q [1:DEPTH-1];
  logic [WIDTH-1:0] mem_d [1:DEPTH-1];
  logic [WIDTH-1:0] word_view [DEPTH];

  // Gated by the strobe first so an unknown rdNum cannot raise any enable.
  always_comb begin
    word_en = '0;
    if (rdWriteEnable) begin
      for (int k = 0; k < DEPTH; k++) begin
        word_en[k] = (rdNum == k[ADDR_WIDTH-1:0]);
      end
    end
  end

  always_comb begin
    for (int k = 1; k < DEPTH; k++) begin
      mem_d[k] = mem_q[k];
      if (word_en[k]) begin
        mem_d[k] = rdData;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 1; k < DEPTH; k++) begin
      if (reset) begin
        mem_q[k] <= '0;
      end else begin
        mem_q[k] <= mem_d[k];
      end
    end
  end

  always_comb begin
    word_view[0] = '0;
    for (int k = 1; k < DEPTH; k++) begin
      word_view[k] = mem_q[k];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_rs;
  logic fwd_rt;

  always_comb begin
    fwd_rs = rdWriteEnable && !reset && (rdNum != '0) && (rsNum == rdNum);
    fwd_rt = rdWriteEnable && !reset && (rdNum != '0) && (rtNum == rdNum);
    rsData = fwd_rs ? rdData : word_view[rsNum];
    rtData = fwd_rt ? rdData : word_view[rtNum];
  end
`else
  always_comb begin
    rsData = word_view[rsNum];
    rtData = word_view[rtNum];
  end
`endif

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - directed self-checking bench for regfile_2r1w.
module tb_regfile_2r1w;
  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 5;

  logic                  clk;
  logic                  reset;
  logic [ADDR_WIDTH-1:0] rsNum;
  logic [WIDTH-1:0]      rsData;
  logic [ADDR_WIDTH-1:0] rtNum;
  logic [WIDTH-1:0]      rtData;
  logic [ADDR_WIDTH-1:0] rdNum;
  logic [WIDTH-1:0]      rdData;
  logic                  rdWriteEnable;

  int checks = 0;
  int errors = 0;

  regfile_2r1w #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk(clk),
    .reset(reset),
    .rsNum(rsNum),
    .rsData(rsData),
    .rtNum(rtNum),
    .rtData(rtData),
    .rdNum(rdNum),
    .rdData(rdData),
    .rdWriteEnable(rdWriteEnable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [ADDR_WIDTH-1:0] num, input logic [WIDTH-1:0] data);
    rdNum = num;
    rdData = data;
    rdWriteEnable = 1'b1;
    tick();
    rdWriteEnable = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rsNum = 5'd5;
    rtNum = 5'd31;
    #1;
    checks++;
    if (rsData !== 32'd0) begin
      errors++;
      $display("FAIL reset_rs: got %h expected %h", rsData, 32'd0);
    end
    checks++;
    if (rtData !== 32'd0) begin
      errors++;
      $display("FAIL reset_rt: got %h expected %h", rtData, 32'd0);
    end
  endtask

  task automatic test_write_hold();
    write_word(5'd3, 32'd88);
    rsNum = 5'd3;
    #1;
    checks++;
    if (rsData !== 32'd88) begin
      errors++;
      $display("FAIL write3: got %0d expected %0d", rsData, 88);
    end
    rdNum = 5'd3;
    rdData = 32'd89;
    rdWriteEnable = 1'b0;
    tick();
    checks++;
    if (rsData !== 32'd88) begin
      errors++;
      $display("FAIL hold3: got %0d expected %0d", rsData, 88);
    end
  endtask

  task automatic test_word0();
    write_word(5'd0, 32'hDEADBEEF);
    rsNum = 5'd0;
    rtNum = 5'd0;
    #1;
    checks++;
    if (rsData !== 32'd0) begin
      errors++;
      $display("FAIL word0_rs: got %h expected %h", rsData, 32'd0);
    end
    checks++;
    if (rtData !== 32'd0) begin
      errors++;
      $display("FAIL word0_rt: got %h expected %h", rtData, 32'd0);
    end
  endtask

  task automatic test_reset_override();
    write_word(5'd7, 32'd90);
    rsNum = 5'd7;
    #1;
    checks++;
    if (rsData !== 32'd90) begin
      errors++;
      $display("FAIL write7: got %0d expected %0d", rsData, 90);
    end
    // A reset pulse that is gone before the edge must not clear anything.
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
    checks++;
    if (rsData !== 32'd90) begin
      errors++;
      $display("FAIL reset_between_edges: got %0d expected %0d", rsData, 90);
    end
    reset = 1'b1;
    rdNum = 5'd7;
    rdData = 32'd91;
    rdWriteEnable = 1'b1;
    tick();
    reset = 1'b0;
    rdWriteEnable = 1'b0;
    #1;
    checks++;
    if (rsData !== 32'd0) begin
      errors++;
      $display("FAIL reset_over_write: got %0d expected %0d", rsData, 0);
    end
    rsNum = 5'd3;
    #1;
    checks++;
    if (rsData !== 32'd0) begin
      errors++;
      $display("FAIL reset_clears3: got %0d expected %0d", rsData, 0);
    end
  endtask

  task automatic test_sweep();
    logic [WIDTH-1:0] exp_s;
    logic [WIDTH-1:0] exp_t;
    int bad;
    for (int k = 1; k < 32; k++) begin
      write_word(k[ADDR_WIDTH-1:0], 32'(100 + k));
    end
    rdNum = 'x;
    rdData = 32'hFFFF_FFFF;
    rdWriteEnable = 1'b0;
    tick();
    bad = 0;
    for (int s = 0; s < 32; s++) begin
      for (int t = 0; t < 32; t++) begin
        rsNum = s[ADDR_WIDTH-1:0];
        rtNum = t[ADDR_WIDTH-1:0];
        exp_s = (s == 0) ? 32'd0 : 32'(100 + s);
        exp_t = (t == 0) ? 32'd0 : 32'(100 + t);
        #1;
        checks++;
        if (rsData !== exp_s || rtData !== exp_t) begin
          errors++;
          if (bad < 8) begin
            $display("FAIL sweep rs=%0d rt=%0d: got %0d/%0d expected %0d/%0d",
                     s, t, rsData, rtData, exp_s, exp_t);
          end
          bad++;
        end
      end
    end
    rdNum = 5'd0;
  endtask

  task automatic test_back_to_back();
    rdNum = 5'd4;
    rdData = 32'd1;
    rdWriteEnable = 1'b1;
    tick();
    rdData = 32'd2;
    tick();
    rdWriteEnable = 1'b0;
    rsNum = 5'd4;
    rtNum = 5'd4;
    #1;
    checks++;
    if (rsData !== 32'd2 || rtData !== 32'd2) begin
      errors++;
      $display("FAIL back_to_back: got %0d/%0d expected %0d", rsData, rtData, 2);
    end
  endtask

  task automatic test_bypass();
    logic [WIDTH-1:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
    exp_pre = 32'h1234;
`else
    exp_pre = 32'd109;
`endif
    rsNum = 5'd9;
    rtNum = 5'd9;
    rdNum = 5'd9;
    rdData = 32'h1234;
    rdWriteEnable = 1'b1;
    #1;
    checks++;
    if (rsData !== exp_pre || rtData !== exp_pre) begin
      errors++;
      $display("FAIL bypass_pre: got %h/%h expected %h", rsData, rtData, exp_pre);
    end
    tick();
    rdWriteEnable = 1'b0;
    #1;
    checks++;
    if (rsData !== 32'h1234 || rtData !== 32'h1234) begin
      errors++;
      $display("FAIL bypass_post: got %h/%h expected %h", rsData, rtData, 32'h1234);
    end
    rsNum = 5'd0;
    rtNum = 5'd10;
    rdNum = 5'd0;
    rdData = 32'hCAFE;
    rdWriteEnable = 1'b1;
    #1;
    checks++;
    if (rsData !== 32'd0 || rtData !== 32'd110) begin
      errors++;
      $display("FAIL bypass_r0: got %0d/%0d expected %0d/%0d", rsData, rtData, 0, 110);
    end
    rdWriteEnable = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    rsNum = '0;
    rtNum = '0;
    rdNum = '0;
    rdData = '0;
    rdWriteEnable = 1'b0;
    @(negedge clk);
    test_reset();
    test_write_hold();
    test_word0();
    test_reset_override();
    test_sweep();
    test_back_to_back();
    test_bypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Register file built from 32-bit enabled, resettable storage words; sits directly downstream of the single-register storage element.
- Consumes the write data/enable produced by the writeback path and supplies two operands to the ALU/decode stage.
- One write port is decoded into per-word enables; two read ports are asynchronous.
- Word 0 is hardwired to zero.

Parameters:
WIDTH, 32, data width of each word
ADDR_WIDTH, 5, register-number width; word count = 2**ADDR_WIDTH (32)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high; clears every word
rsNum  input  ADDR_WIDTH  read port A register number
rsData  output  WIDTH  read port A data
rtNum  input  ADDR_WIDTH  read port B register number
rtData  output  WIDTH  read port B data
rdNum  input  ADDR_WIDTH  write register number
rdData  input  WIDTH  write data
rdWriteEnable  input  1  write strobe, sampled on rising clk

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset); no other clocks or async paths.
- Storage is 2**ADDR_WIDTH words of WIDTH bits.
  - Word k loads rdData on a rising clk when rdWriteEnable=1, rdNum=k, k!=0 and reset=0.
  - Otherwise word k holds.
- Write decode: exactly one word enable is asserted when rdWriteEnable=1; none when rdWriteEnable=0. An rdNum of X must not corrupt any word when rdWriteEnable=0.
- Word 0 is never written.
  - rsData/rtData read 0 whenever the corresponding number is 0, regardless of writes.
- Reads are combinational.
  - rsData = word[rsNum], rtData = word[rtNum].
  - Latency 0 from a number change to data; a write becomes visible on the read ports immediately after the rising edge that commits it.
- Reset:
  - Any rising clk with reset=1 sets all words to 0.
  - Reset overrides a simultaneous write: the word ends at 0, not rdData.
  - Reset is sampled only on clk edges; asserting it between edges has no effect until the next rising edge.
  - Reset value of rsData/rtData is 0 for any rsNum/rtNum.
- Simultaneous events:
  - Both read ports may address the same word, including the word being written; each returns the pre-edge value until the edge unless the optional bypass is compiled in.
  - Back-to-back writes to the same word: the last committed write wins.
- No X-propagation from unwritten words after the first reset; before the first reset the contents are undefined and the bench must not check them.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. When rdWriteEnable=1, reset=0, rdNum!=0 and rsNum==rdNum, then rsData=rdData in the same cycle, before the edge. The same rule applies independently for rtNum/rtData. The rdNum=0 write is not forwarded; the read returns 0. No forwarding while reset=1.
- Undefined: no forwarding; reads always return stored contents (the behaviour described above).
- Storage update timing is identical in both builds.

Test Plan:
- Reset 1 cycle, then read rsNum=5, rtNum=31 -> rsData=0, rtData=0.
- Write rdNum=3, rdData=88, rdWriteEnable=1 for one edge; rsNum=3 -> rsData=88 after the edge. Then rdWriteEnable=0, rdData=89, rdNum=3 for one edge -> still 88.
- Write rdNum=0, rdData=0xDEADBEEF -> rsNum=0 and rtNum=0 both read 0 after the edge.
- Write word 7=90, then assert reset=1 with rdWriteEnable=1, rdNum=7, rdData=91 on the same edge -> word 7 reads 0 afterwards.
- Write words 1..31 with value 100+k, then sweep rsNum and rtNum over all pairs -> each reads 100+k, and word 0 reads 0; confirms decode has no aliasing.
- With rdWriteEnable=1, rdNum=9, rdData=0x1234 and rsNum=rtNum=9 before the edge -> reads 0x1234 pre-edge only with REGFILE_BYPASS_EN, the old value without it; both builds read 0x1234 after the edge.
